// File: rtl/dct_da_pkg.sv
// dct_da_pkg: shared widths, state encoding and slice-counter sizing for the DA Z-row engines
package dct_da_pkg;
  localparam int IN_W      = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;
  localparam int ACC_W     = COEF_W + IN_W + 2;
  localparam int K_W       = $clog2(IN_W);
  typedef enum logic [1:0] {IDLE, RUN, OFFS, DONE} state_e;
endpackage

// File: rtl/da_slice_fold.sv
// da_slice_fold: maps a 4-bit DA slice onto the half-size offset-binary ROM via symmetry
module da_slice_fold (
  input  logic [3:0] slice,
  output logic [2:0] addr,
  output logic       neg
);
  // x0 bit set selects the mirrored half: complement the address and negate the word
  always_comb begin
    neg  = slice[0];
    addr = slice[0] ? ~{slice[1], slice[2], slice[3]} : {slice[1], slice[2], slice[3]};
  end
endmodule

// File: rtl/dct_da_z5_engine.sv
// dct_da_z5_engine: bit-serial DA engine for DCT output Z5 (optional rounding via DA_ROUND_EN)
module dct_da_z5_engine
  import dct_da_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          x0,
  input  logic [IN_W-1:0]          x1,
  input  logic [IN_W-1:0]          x2,
  input  logic [IN_W-1:0]          x3,
  output logic                     rom_cs,
  output logic [2:0]               rom_addr,
  input  logic [COEF_W-1:0]        rom_data,
  output logic signed [ACC_W-1:0]  y,
  output logic                     out_valid,
  input  logic                     out_ready
);
  state_e                   state_q;
  logic                     sync_q;
  logic [K_W-1:0]           k_q;
  logic [IN_W-1:0]          x_q [4];
  logic signed [ACC_W-1:0]  acc_q, acc_d, rom_ext, f;
  logic [2:0]               f_addr;
  logic                     f_neg;
  logic                     out_valid_q;

  da_slice_fold u_fold (
    .slice({x_q[3][k_q], x_q[2][k_q], x_q[1][k_q], x_q[0][k_q]}),
    .addr (f_addr),
    .neg  (f_neg)
  );

  // ROM drive, folded slice value and Horner-style shift-accumulate (MSB slice carries negative weight)
  always_comb begin
    in_ready  = sync_q && state_q == IDLE;
    out_valid = out_valid_q;
    rom_cs    = state_q == RUN || state_q == OFFS;
    rom_addr  = state_q == RUN ? f_addr : 3'b000;
    rom_ext   = {{(ACC_W-COEF_W){rom_data[COEF_W-1]}}, rom_data};
    f         = f_neg ? -rom_ext : rom_ext;
    acc_d     = state_q == RUN  ? (k_q == K_W'(IN_W-1) ? -f : (acc_q <<< 1) + f) :
                state_q == OFFS ? acc_q + rom_ext : acc_q;
  end

`ifdef DA_ROUND_EN
  logic signed [ACC_W-1:0] rnd;
  // round half up to integer, saturate to 16 bits, present only while DONE
  always_comb begin
    rnd = (acc_q + (ACC_W'(1) <<< (COEF_FRAC-1))) >>> COEF_FRAC;
    y   = state_q != DONE        ? '0 :
          rnd > ACC_W'(32767)    ? ACC_W'(32767) :
          rnd < -ACC_W'(32768)   ? -ACC_W'(32768) : rnd;
  end
`else
  // full-precision Q.14 result, present only while DONE so partial sums never leak
  always_comb y = state_q == DONE ? acc_q : '0;
`endif

  // control FSM: reset sync, sample latch, slice countdown, result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 1'b0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      x_q         <= '{default: '0};
    end else begin
      sync_q <= 1'b1;
      acc_q  <= acc_d;
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          x_q     <= '{x0, x1, x2, x3};
          k_q     <= K_W'(IN_W-1);
          state_q <= RUN;
        end
        RUN: begin
          k_q <= k_q - 1'b1;
          if (k_q == '0) state_q <= OFFS;
        end
        OFFS: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dct_da_z5_engine.sv
// tb_dct_da_z5_engine: directed checks of the Z5 DA engine against the linear-combination model
module tb_dct_da_z5_engine;
  localparam int C5 = 9104, C1 = 16070, C7 = 3196, C3 = 13622;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0, out_ready = 1'b0;
  logic               in_ready, rom_cs, out_valid;
  logic [15:0]        x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic [2:0]         rom_addr;
  logic [15:0]        rom_data;
  logic signed [33:0] y;
  int                 rom_val;
  int                 total = 0, bad = 0;

  dct_da_z5_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // external ROM: R = 0.5*(s0*c5 - s1*c1 + s2*c7 + s3*c3), s0 = -1, addr = {s1,s2,s3}; even coefficients keep halves exact
  always_comb begin
    rom_val  = -C5 + (rom_addr[2] ? -C1 : C1) + (rom_addr[1] ? C7 : -C7) + (rom_addr[0] ? C3 : -C3);
    rom_data = 16'(rom_val / 2);
  end

  function automatic longint expy(input longint a, b, c, d);
    longint v;
    v = C5 * a - C1 * b + C7 * c + C3 * d;
`ifdef DA_ROUND_EN
    v = (v + 8192) >>> 14;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic signed [15:0] a, b, c, d);
    int n = 0;
    while (!in_ready && n < 64) begin @(negedge clk); n++; end
    chk("issue_ready", in_ready, 1);
    x0 = a; x1 = b; x2 = c; x3 = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input longint e, input string tag);
    int lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, lat, 17);
    chk({tag, "_y"}, y, e);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
  endtask

  task automatic run(input logic signed [15:0] a, b, c, d, input string tag);
    issue(a, b, c, d);
    collect(expy(a, b, c, d), tag);
    release_out();
  endtask

  initial begin
    logic signed [33:0] yh;
    logic signed [15:0] r [4];
    #3 rst_n = 1'b0;
    #20;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    #1 chk("sync_ready_lo", in_ready, 0);
    @(negedge clk);
    chk("sync_ready_hi", in_ready, 1);
    in_valid = 1'b0;

    run(16'sd0, 16'sd0, 16'sd0, 16'sd0, "zero");
    run(16'sd1, 16'sd0, 16'sd0, 16'sd0, "one");
    run(-16'sd1, 16'sd0, 16'sd0, 16'sd0, "minus_one");
    run(16'sd0, 16'sd1, 16'sd0, 16'sd0, "x1_one");
    run(16'sd32767, -16'sd32768, 16'sd32767, 16'sd32767, "max_pos");
    run(-16'sd32768, 16'sd32767, -16'sd32768, -16'sd32768, "max_neg");
    run(16'sd1234, -16'sd567, 16'sd89, -16'sd4321, "mixed");
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) r[j] = 16'($urandom);
      run(r[0], r[1], r[2], r[3], $sformatf("rand%0d", i));
    end

    issue(16'sd300, -16'sd200, 16'sd100, 16'sd50);
    collect(expy(300, -200, 100, 50), "hold");
    yh = y;
    x0 = 16'sd7; x1 = 16'sd7; x2 = 16'sd7; x3 = 16'sd7;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_y", y, yh);
      chk("hold_in_ready", in_ready, 0);
    end
    chk("hold_out_valid", out_valid, 1);
    in_valid = 1'b0;
    release_out();
    run(-16'sd9, 16'sd3, 16'sd11, -16'sd5, "after_hold");

    issue(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000);
    repeat (8) @(negedge clk);
    chk("mid_rom_cs", rom_cs, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rom_cs", rom_cs, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel_ready_lo", in_ready, 0);
    @(negedge clk);
    chk("mid_rel_ready_hi", in_ready, 1);
    repeat (20) @(negedge clk);
    chk("mid_no_result", out_valid, 0);
    run(16'sd2, 16'sd4, -16'sd8, 16'sd16, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
